// File: rtl/rs_mul.sv
// Reservation station for the pipelined multiplier: buffers MUL-class ops, wakes them from the CDB, issues oldest-ready.
// Optional macro RS_MUL_CDB_FORWARD_EN: allow an entry woken by the current CDB broadcast to issue in the same cycle.
`timescale 1ns/1ps

package rs_mul_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned PRF_LEN  = 6;
    localparam int unsigned ROB_LEN  = 5;
    localparam int unsigned FUNC_LEN = 5;

    typedef enum logic [FUNC_LEN-1:0] {
        ALU_ADD    = 5'h00,
        ALU_SUB    = 5'h01,
        ALU_SLT    = 5'h02,
        ALU_SLTU   = 5'h03,
        ALU_AND    = 5'h04,
        ALU_OR     = 5'h05,
        ALU_XOR    = 5'h06,
        ALU_SLL    = 5'h07,
        ALU_SRL    = 5'h08,
        ALU_SRA    = 5'h09,
        ALU_MUL    = 5'h0A,
        ALU_MULH   = 5'h0B,
        ALU_MULHSU = 5'h0C,
        ALU_MULHU  = 5'h0D
    } alu_func_t;

    // Issue payload handed to the multiplier.
    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    opa_value;
        logic [XLEN-1:0]    opb_value;
        logic [PRF_LEN-1:0] dest_preg_idx;
        logic [ROB_LEN-1:0] rob_idx;
        alu_func_t          mul_func;
    } rs_mul_packet_t;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [PRF_LEN-1:0] dest_preg_idx;
        logic [ROB_LEN-1:0] rob_idx;
        alu_func_t          mul_func;
        logic               opa_ready;
        logic [PRF_LEN-1:0] opa_preg;
        logic [XLEN-1:0]    opa_value;
        logic               opb_ready;
        logic [PRF_LEN-1:0] opb_preg;
        logic [XLEN-1:0]    opb_value;
    } rs_entry_t;

endpackage

module rs_mul
    import rs_mul_pkg::*;
#(
    parameter int unsigned RS_MUL_SIZE = 4,
    parameter int unsigned RS_MUL_LEN  = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                squash,
    input  logic                dispatch_enable,
    input  logic [XLEN-1:0]     dispatch_PC,
    input  logic [PRF_LEN-1:0]  dispatch_dest_preg_idx,
    input  logic [ROB_LEN-1:0]  dispatch_rob_idx,
    input  alu_func_t           dispatch_mul_func,
    input  logic                dispatch_opa_ready,
    input  logic [PRF_LEN-1:0]  dispatch_opa_preg,
    input  logic [XLEN-1:0]     dispatch_opa_value,
    input  logic                dispatch_opb_ready,
    input  logic [PRF_LEN-1:0]  dispatch_opb_preg,
    input  logic [XLEN-1:0]     dispatch_opb_value,
    input  logic                cdb_valid,
    input  logic [PRF_LEN-1:0]  cdb_preg_idx,
    input  logic [XLEN-1:0]     cdb_value,
    input  logic                mul_free,
    output rs_mul_packet_t      rs_mul_packet,
    output logic                mul_enable,
    output logic                rs_mul_full
);

    rs_entry_t               entry     [RS_MUL_SIZE];
    rs_entry_t               entry_nxt [RS_MUL_SIZE];
    rs_entry_t               disp_entry;
    // older_mask[i][j] = entry j was dispatched before entry i
    logic [RS_MUL_SIZE-1:0]  older_mask     [RS_MUL_SIZE];
    logic [RS_MUL_SIZE-1:0]  older_mask_nxt [RS_MUL_SIZE];
    logic [RS_MUL_SIZE-1:0]  valid;
    logic [RS_MUL_SIZE-1:0]  valid_nxt;
    logic [RS_MUL_SIZE-1:0]  wake_a;
    logic [RS_MUL_SIZE-1:0]  wake_b;
    logic [RS_MUL_SIZE-1:0]  rdy_a;
    logic [RS_MUL_SIZE-1:0]  rdy_b;
    logic [RS_MUL_SIZE-1:0]  eligible;
    logic [RS_MUL_SIZE-1:0]  sel_oh;
    logic [RS_MUL_LEN-1:0]   sel_idx;
    logic [RS_MUL_LEN-1:0]   free_idx;
    logic                    any_eligible;
    logic                    dispatch_fire;
    logic                    cap_a;
    logic                    cap_b;

    // CDB tag match and effective readiness per entry
    always_comb begin
        wake_a   = '0;
        wake_b   = '0;
        rdy_a    = '0;
        rdy_b    = '0;
        eligible = '0;
        for (int i = 0; i < int'(RS_MUL_SIZE); i++) begin
            wake_a[i] = valid[i] & ~entry[i].opa_ready & cdb_valid
                        & (entry[i].opa_preg == cdb_preg_idx);
            wake_b[i] = valid[i] & ~entry[i].opb_ready & cdb_valid
                        & (entry[i].opb_preg == cdb_preg_idx);
`ifdef RS_MUL_CDB_FORWARD_EN
            rdy_a[i] = entry[i].opa_ready | wake_a[i];
            rdy_b[i] = entry[i].opb_ready | wake_b[i];
`else
            rdy_a[i] = entry[i].opa_ready;
            rdy_b[i] = entry[i].opb_ready;
`endif
            eligible[i] = valid[i] & rdy_a[i] & rdy_b[i];
        end
    end

    // Oldest eligible entry: eligible with no older eligible entry
    always_comb begin
        sel_oh       = '0;
        sel_idx      = '0;
        any_eligible = |eligible;
        for (int i = 0; i < int'(RS_MUL_SIZE); i++) begin
            sel_oh[i] = eligible[i] & ~|(eligible & older_mask[i]);
        end
        for (int i = int'(RS_MUL_SIZE) - 1; i >= 0; i--) begin
            if (sel_oh[i]) begin
                sel_idx = RS_MUL_LEN'(i);
            end
        end
    end

    // Lowest-index free slot for dispatch
    always_comb begin
        free_idx = '0;
        for (int i = int'(RS_MUL_SIZE) - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = RS_MUL_LEN'(i);
            end
        end
    end

    assign mul_enable    = mul_free & any_eligible & ~squash;
    assign dispatch_fire = dispatch_enable & ~rs_mul_full & ~squash;

    // Issue payload, zero when nothing issues
    always_comb begin
        rs_mul_packet = '0;
        if (mul_enable) begin
            rs_mul_packet.pc            = entry[sel_idx].pc;
            rs_mul_packet.opa_value     = entry[sel_idx].opa_value;
            rs_mul_packet.opb_value     = entry[sel_idx].opb_value;
            rs_mul_packet.dest_preg_idx = entry[sel_idx].dest_preg_idx;
            rs_mul_packet.rob_idx       = entry[sel_idx].rob_idx;
            rs_mul_packet.mul_func      = entry[sel_idx].mul_func;
`ifdef RS_MUL_CDB_FORWARD_EN
            if (!entry[sel_idx].opa_ready) begin
                rs_mul_packet.opa_value = cdb_value;
            end
            if (!entry[sel_idx].opb_ready) begin
                rs_mul_packet.opb_value = cdb_value;
            end
`endif
        end
    end

    // Incoming op, with operands captured from a coincident broadcast
    always_comb begin
        cap_a = ~dispatch_opa_ready & cdb_valid & (dispatch_opa_preg == cdb_preg_idx);
        cap_b = ~dispatch_opb_ready & cdb_valid & (dispatch_opb_preg == cdb_preg_idx);
        disp_entry               = '0;
        disp_entry.pc            = dispatch_PC;
        disp_entry.dest_preg_idx = dispatch_dest_preg_idx;
        disp_entry.rob_idx       = dispatch_rob_idx;
        disp_entry.mul_func      = dispatch_mul_func;
        disp_entry.opa_ready     = dispatch_opa_ready | cap_a;
        disp_entry.opa_preg      = dispatch_opa_preg;
        disp_entry.opa_value     = cap_a ? cdb_value : dispatch_opa_value;
        disp_entry.opb_ready     = dispatch_opb_ready | cap_b;
        disp_entry.opb_preg      = dispatch_opb_preg;
        disp_entry.opb_value     = cap_b ? cdb_value : dispatch_opb_value;
    end

    // Next state: wakeup, issue, dispatch, squash (later wins)
    always_comb begin
        valid_nxt = valid;
        for (int i = 0; i < int'(RS_MUL_SIZE); i++) begin
            entry_nxt[i]      = entry[i];
            older_mask_nxt[i] = older_mask[i];
            if (wake_a[i]) begin
                entry_nxt[i].opa_ready = 1'b1;
                entry_nxt[i].opa_value = cdb_value;
            end
            if (wake_b[i]) begin
                entry_nxt[i].opb_ready = 1'b1;
                entry_nxt[i].opb_value = cdb_value;
            end
        end
        if (mul_enable) begin
            valid_nxt[sel_idx] = 1'b0;
        end
        if (dispatch_fire) begin
            valid_nxt[free_idx] = 1'b1;
            entry_nxt[free_idx] = disp_entry;
            for (int i = 0; i < int'(RS_MUL_SIZE); i++) begin
                older_mask_nxt[i][free_idx] = 1'b0;
            end
            older_mask_nxt[free_idx] = valid;
        end
        if (squash) begin
            valid_nxt = '0;
            for (int i = 0; i < int'(RS_MUL_SIZE); i++) begin
                older_mask_nxt[i] = '0;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid       <= '0;
            rs_mul_full <= 1'b0;
            for (int i = 0; i < int'(RS_MUL_SIZE); i++) begin
                older_mask[i] <= '0;
                entry[i]      <= '0;
            end
        end else begin
            valid       <= valid_nxt;
            rs_mul_full <= &valid_nxt;
            for (int i = 0; i < int'(RS_MUL_SIZE); i++) begin
                older_mask[i] <= older_mask_nxt[i];
                entry[i]      <= entry_nxt[i];
            end
        end
    end

endmodule

// File: doc/rs_mul.md
Name: rs_mul

Overview:
- Reservation station for the pipelined multiply unit, on the issuing side of the multiplier's RS_MUL_PACKET / mul_enable / mul_free interface.
- Buffers dispatched MUL/MULH/MULHSU/MULHU ops and captures source operands from CDB broadcasts.
- Issues the oldest fully-ready entry to the multiplier, at most one per cycle, whenever mul_free is high.
- Sits between dispatch and the multiplier; results return via the CDB and are not seen here.

Parameters:
- RS_MUL_SIZE, 4, number of entries (power of two, 2..16).
- RS_MUL_LEN, 2, log2(RS_MUL_SIZE); entry index width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately when low.
- squash  in  1  mispredict flush; synchronous, all entries invalidated at next edge.
- dispatch_enable  in  1  write one new op this cycle; ignored when rs_mul_full=1.
- dispatch_PC  in  XLEN  PC of the op.
- dispatch_dest_preg_idx  in  PRF_LEN  destination physical register.
- dispatch_rob_idx  in  ROB_LEN  ROB slot of the op.
- dispatch_mul_func  in  ALU_FUNC  one of ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU.
- dispatch_opa_ready  in  1  opa value valid at dispatch.
- dispatch_opa_preg  in  PRF_LEN  opa tag.
- dispatch_opa_value  in  XLEN  opa value.
- dispatch_opb_ready  in  1  opb value valid at dispatch.
- dispatch_opb_preg  in  PRF_LEN  opb tag.
- dispatch_opb_value  in  XLEN  opb value.
- cdb_valid  in  1  CDB broadcast valid.
- cdb_preg_idx  in  PRF_LEN  broadcast tag.
- cdb_value  in  XLEN  broadcast value.
- mul_free  in  1  multiplier accepts an op this cycle.
- rs_mul_packet  out  RS_MUL_PACKET  PC, opa_value, opb_value, dest_preg_idx, rob_idx, mul_func of the issued op.
- mul_enable  out  1  rs_mul_packet valid; the multiplier's start.
- rs_mul_full  out  1  all entries valid.

Behaviour:
- Per-entry state:
  - valid, opa_ready/opa_preg/opa_value, opb_ready/opb_preg/opb_value, PC, dest, rob_idx, func.
  - age matrix bit older[j][i] = entry j was dispatched before entry i.
- Reset (reset=0, asynchronous):
  - all valid=0, all age bits 0.
  - mul_enable=0, rs_mul_full=0, rs_mul_packet=0.
- Dispatch:
  - When dispatch_enable=1 and rs_mul_full=0, write the lowest-index invalid entry k.
  - Set older[j][k]=valid[j] for all j; clear older[k][*].
- Dispatch-time capture: if cdb_valid=1 and cdb_preg_idx equals a not-ready dispatch tag, that operand is stored ready with cdb_value.
- Wakeup:
  - Each valid entry with a not-ready operand whose tag equals cdb_preg_idx while cdb_valid=1 stores cdb_value and becomes ready at the next edge.
  - Both operands can wake on the same broadcast.
- Issue (combinational):
  - Eligible entries: valid, both operands ready.
  - Select the eligible entry i with no eligible j where older[j][i]=1.
  - mul_enable = mul_free & any eligible & ~squash.
  - rs_mul_packet is driven from the selected entry; it is all-zero when mul_enable=0.
  - The issued entry's valid clears at the edge.
- Latency: an operand-ready op dispatched in cycle t issues no earlier than t+1. There is no same-cycle dispatch-to-issue path.
- rs_mul_full is registered: 1 iff all entries valid after the edge.
  - Dispatch in a full cycle is dropped even if an issue frees an entry that cycle.
- Simultaneous issue and dispatch: legal when not full. A freed index is reusable from the next cycle.
- Squash:
  - All valid and age bits clear at the edge.
  - mul_enable=0 in the squash cycle.
  - Dispatch in the squash cycle is dropped.
- reset asserted mid-operation: immediate clear. Any op issued in the previous cycle is the multiplier's responsibility.

Optional Feature:
- Macro: RS_MUL_CDB_FORWARD_EN.
- Defined: an entry whose last missing operand(s) match the current CDB broadcast is eligible this cycle. The matching operand on rs_mul_packet is muxed from cdb_value. Wakeup-to-issue latency is 0 cycles.
- Undefined: a woken entry is eligible only from the next cycle, taking values from entry storage. Wakeup-to-issue latency is 1 cycle.

Test Plan:
1. Reset low mid-run with 3 valid entries -> mul_enable=0, rs_mul_full=0 immediately; after release, a dispatch of an op with both operands ready -> issues next cycle.
2. Dispatch MUL opa=0x7 opb=0xFFFFFFFD (both ready), mul_free=1 -> next cycle mul_enable=1, packet operands 0x7/0xFFFFFFFD, func ALU_MUL, then entry empty.
3. Fill 4 entries with opb waiting on preg 12; broadcast cdb preg 12 value 0x5 -> all wake. Issue order follows dispatch order over 4 consecutive cycles, each opb_value=0x5.
4. Full RS plus dispatch_enable=1 while one entry issues -> dispatch dropped, rs_mul_full deasserts next cycle, retry succeeds.
5. mul_free=0 for 5 cycles with 2 ready entries -> mul_enable=0 throughout; mul_free=1 -> oldest issues first.
6. squash with 3 valid entries plus dispatch the same cycle -> next cycle no valid entries, rs_mul_full=0; CDB match on the old tag causes no issue.
